// File: rtl/addsub_issue_stage.sv
// Issue/capture stage around an external combinational WIDTH-bit adder with a 2-entry result FIFO.
// Optional macro ADDSUB_SAT_EN saturates out_sum on signed overflow.
module addsub_issue_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    input  logic             in_chain,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int MSB = WIDTH - 1;

    logic             s1_v;
    logic             carry_q;
    logic [1:0]       count;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [WIDTH-1:0] res_sum [2];
    logic [1:0]       res_cout;
    logic [1:0]       res_ovf;
    logic [1:0]       res_zero;

    logic             accept;
    logic             capture;
    logic             pop;
    logic             carry_fwd;
    logic             cap_ovf;
    logic             cap_zero;
    logic [WIDTH-1:0] cap_sum;

    assign capture   = s1_v && (count != 2'd2);
    assign in_ready  = !s1_v || (count != 2'd2);
    assign accept    = in_valid && in_ready;
    assign pop       = (count != 2'd0) && out_ready;
    // A back-to-back chained word must see the carry being captured this very cycle.
    assign carry_fwd = capture ? add_cout : carry_q;

    always_comb begin
        cap_ovf = (add_a[MSB] == add_b[MSB]) && (add_sum[MSB] != add_a[MSB]);
        cap_sum = add_sum;
`ifdef ADDSUB_SAT_EN
        if (cap_ovf) begin
            cap_sum = add_a[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
        end
`endif
        cap_zero = (cap_sum == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
        end else if (accept) begin
            s1_v    <= 1'b1;
            add_a   <= in_a;
            add_b   <= in_sub ? ~in_b : in_b;
            add_cin <= in_chain ? carry_fwd : (in_sub ? ~in_cin : in_cin);
        end else if (capture) begin
            s1_v    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            if (capture) begin
                wr_ptr  <= ~wr_ptr;
                carry_q <= add_cout;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({capture, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: outputs are masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (capture) begin
            res_sum[wr_ptr]  <= cap_sum;
            res_cout[wr_ptr] <= add_cout;
            res_ovf[wr_ptr]  <= cap_ovf;
            res_zero[wr_ptr] <= cap_zero;
        end
    end

    assign out_valid = (count != 2'd0);
    assign out_sum   = out_valid ? res_sum[rd_ptr]  : '0;
    assign out_cout  = out_valid ? res_cout[rd_ptr] : 1'b0;
    assign out_ovf   = out_valid ? res_ovf[rd_ptr]  : 1'b0;
    assign out_zero  = out_valid ? res_zero[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_addsub_issue_stage.sv
// Scoreboard bench for addsub_issue_stage; supplies a behavioural adder and a reference model.
module tb_addsub_issue_stage;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic        in_cin;
    logic        in_chain;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;

    int   checks = 0;
    int   errors = 0;
    int   pop_count = 0;
    logic model_carry = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    addsub_issue_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin), .in_chain(in_chain),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every result leaving the DUT is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected: got sum=%h with no expected result", out_sum);
            end else begin
                mon_e = sb.pop_front();
                pop_count++;
                if ({out_sum, out_cout, out_ovf, out_zero} !== {mon_e.sum, mon_e.cout, mon_e.ovf, mon_e.zero}) begin
                    errors++;
                    $display("[TB] FAIL sb_result: got sum=%h c=%b v=%b z=%b, want sum=%h c=%b v=%b z=%b",
                             out_sum, out_cout, out_ovf, out_zero, mon_e.sum, mon_e.cout, mon_e.ovf, mon_e.zero);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic cin, input logic chain, output int waits);
        logic        ok;
        logic [31:0] bb;
        logic        c;
        logic [32:0] r;
        exp_t        e;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_cin   = cin;
        in_chain = chain;
        ok       = 1'b0;
        waits    = 0;
        while (!ok && waits < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (!ok) waits++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL issue_timeout: in_ready=%b after %0d cycles, want 1", in_ready, waits);
        end else begin
            bb = sub ? ~b : b;
            c  = chain ? model_carry : (sub ? ~cin : cin);
            r  = {1'b0, a} + {1'b0, bb} + {32'd0, c};
            e.sum  = r[31:0];
            e.cout = r[32];
            e.ovf  = (a[31] == bb[31]) && (r[31] != a[31]);
`ifdef ADDSUB_SAT_EN
            if (e.ovf) e.sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
            e.zero = (e.sum == 32'd0);
            model_carry = r[32];
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain: pending=%0d out_valid=%b, want 0 and 0", sb.size(), out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_cin    = 1'b0;
        in_chain  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_cout, out_ovf, out_zero} !== 5'b10000 || out_sum !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: rdy=%b v=%b sum=%h c=%b o=%b z=%b, want 1 0 0 0 0 0",
                     in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero);
        end
        checks++;
        if (add_a !== 32'd0 || add_b !== 32'd0 || add_cin !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_adder_regs: a=%h b=%h cin=%b, want 0 0 0", add_a, add_b, add_cin);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_add();
        int w;
        out_ready = 1'b1;
        issue(32'h0000_000F, 32'h0000_0001, 1'b0, 1'b1, 1'b0, w);
        @(negedge clk);
        checks++;
        if (add_b !== 32'h1 || add_cin !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_issue: add_b=%h cin=%b v=%b, want 00000001 1 0", add_b, add_cin, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'h11 || {out_cout, out_ovf, out_zero} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL add_result: v=%b sum=%h cvz=%b%b%b, want 1 00000011 000",
                     out_valid, out_sum, out_cout, out_ovf, out_zero);
        end
        drain();
    endtask

    task automatic test_sub_underflow();
        int w;
        out_ready = 1'b1;
        issue(32'h0, 32'h1, 1'b1, 1'b0, 1'b0, w);
        @(negedge clk);
        checks++;
        if (add_b !== 32'hFFFF_FFFE || add_cin !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sub_issue: add_b=%h cin=%b, want fffffffe 1", add_b, add_cin);
        end
        @(negedge clk);
        checks++;
        if (out_sum !== 32'hFFFF_FFFF || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sub_result: sum=%h c=%b o=%b, want ffffffff 0 0", out_sum, out_cout, out_ovf);
        end
        drain();
    endtask

    task automatic test_overflow();
        int          w;
        logic [31:0] want_sum;
        logic        want_zero;
`ifdef ADDSUB_SAT_EN
        want_sum  = 32'h8000_0000;
        want_zero = 1'b0;
`else
        want_sum  = 32'h0000_0000;
        want_zero = 1'b1;
`endif
        out_ready = 1'b1;
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, w);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_sum !== want_sum || out_cout !== 1'b1 || out_ovf !== 1'b1 || out_zero !== want_zero) begin
            errors++;
            $display("[TB] FAIL overflow: sum=%h c=%b o=%b z=%b, want %h 1 1 %b",
                     out_sum, out_cout, out_ovf, out_zero, want_sum, want_zero);
        end
        drain();
    endtask

    task automatic test_chain64();
        int w;
        out_ready = 1'b1;
        issue(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, w);
        issue(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, w);
        @(negedge clk);
        checks++;
        if (add_cin !== 1'b1 || out_sum !== 32'h0 || out_cout !== 1'b1) begin
            errors++;
            $display("[TB] FAIL chain_word0: cin=%b sum=%h c=%b, want 1 00000000 1", add_cin, out_sum, out_cout);
        end
        @(negedge clk);
        checks++;
        if (out_sum !== 32'h1 || out_cout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL chain_word1: sum=%h c=%b, want 00000001 0", out_sum, out_cout);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int w;
        int start_pops;
        start_pops = pop_count;
        out_ready  = 1'b0;
        for (int k = 1; k <= 3; k++) issue(k, 32'h0, 1'b0, 1'b0, 1'b0, w);
        in_valid = 1'b1;
        in_a     = 32'd4;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || add_a !== 32'd3) begin
                errors++;
                $display("[TB] FAIL bp_stall: in_ready=%b add_a=%h, want 0 00000003", in_ready, add_a);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(32'd4, 32'h0, 1'b0, 1'b0, 1'b0, w);
        drain();
        checks++;
        if (pop_count - start_pops != 4) begin
            errors++;
            $display("[TB] FAIL bp_count: results=%0d, want 4", pop_count - start_pops);
        end
    endtask

    task automatic test_reset_midop();
        int w;
        out_ready = 1'b0;
        issue(32'h1, 32'h0, 1'b0, 1'b0, 1'b0, w);
        issue(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, w);
        issue(32'h5, 32'h5, 1'b0, 1'b0, 1'b0, w);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        model_carry = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midop_reset: v=%b rdy=%b sum=%h, want 0 1 00000000", out_valid, in_ready, out_sum);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, w);
        @(negedge clk);
        checks++;
        if (add_cin !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midop_chain_cin: add_cin=%b, want 0", add_cin);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int w;
        int total = 0;
        logic [31:0] a;
        logic [31:0] b;
        out_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            a = (k % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
            b = (k % 7 == 0) ? 32'h8000_0000 : $urandom;
            issue(a, b, 1'(($urandom >> 3) & 1), 1'($urandom & 1), 1'(($urandom >> 5) & 1), w);
            total += w;
        end
        checks++;
        if (total != 0) begin
            errors++;
            $display("[TB] FAIL throughput: stall cycles=%0d, want 0", total);
        end
        drain();
    endtask

    task automatic test_random_backpressure();
        int w;
        fork
            begin
                for (int k = 0; k < 20; k++)
                    issue($urandom, $urandom, 1'($urandom & 1), 1'(($urandom >> 2) & 1),
                          1'(($urandom >> 4) & 1), w);
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_sub_underflow();
        test_overflow();
        test_chain64();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        test_random_backpressure();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_issue_stage.md
Name: addsub_issue_stage

Overview:
- Registered issue and capture stage wrapped around the combinational 32-bit Brent-Kung adder/subtractor.
- Accepts operation requests over a valid/ready handshake and drives the adder's A/B/cin with the inverted-B and carry logic already applied.
- Captures sum/cout into a 2-entry result buffer and adds signed-overflow and zero flags.
- Stores the last carry so multi-word (64/96-bit) add/sub chains can be issued as consecutive words.

Parameters:
- WIDTH, 32, operand/result width; must match the adder.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  stage can accept a request
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_sub  in  1  1 = A-B, 0 = A+B
- in_cin  in  1  add: carry-in; sub: borrow-in (1 = borrow)
- in_chain  in  1  1 = ignore in_cin and use the stored carry from the previous captured result
- add_a  out  WIDTH  to adder A
- add_b  out  WIDTH  to adder B
- add_cin  out  1  to adder cin
- add_sum  in  WIDTH  from adder sum
- add_cout  in  1  from adder cout
- out_valid  out  1  result available (buffer head)
- out_ready  in  1  consumer takes result
- out_sum  out  WIDTH  result
- out_cout  out  1  raw adder carry (for sub: 1 = no borrow)
- out_ovf  out  1  signed overflow
- out_zero  out  1  out_sum == 0

Behaviour:
- Reset: clk/rst_n, synchronous, active-low; sampled on the rising edge.
  - Clears s1_v, buffer count/pointers, carry_q, and add_a/add_b/add_cin.
  - Outputs after reset: in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0.
  - Reset mid-operation discards the in-flight request and all buffered results; no partial output appears.
- Issue register (stage 1):
  - On in_valid && in_ready: add_a <= in_a; add_b <= in_sub ? ~in_b : in_b; s1_v <= 1.
  - add_cin <= in_chain ? carry_q : (in_sub ? ~in_cin : in_cin).
  - Registers also hold the issued sign bits of A and B for the overflow calculation.
- Capture:
  - When s1_v && count<2, push {add_sum, add_cout, ovf, zero} into the buffer and set carry_q <= add_cout.
  - s1_v clears unless a new request is accepted in the same cycle.
  - ovf = (add_a[MSB]==add_b[MSB]) && (add_sum[MSB]!=add_a[MSB]).
  - zero = (add_sum==0).
- Handshakes:
  - in_ready = !s1_v || (count<2). This is registered state only, with no combinational path from out_ready.
  - When s1_v and count==2, s1 stalls and holds its operands, so the adder inputs stay stable.
- Buffer: 2-entry FIFO.
  - out_valid = (count!=0); outputs present the head entry.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle keep count unchanged.
  - A push while full is never attempted.
  - Pointers wrap modulo 2.
- Latency: a request accepted at edge N is captured at edge N+1, so out_valid is high after edge N+1 when the buffer was empty and not stalled.
- Throughput: 1 op/cycle with out_ready held high.
- Chaining:
  - carry_q updates only on capture.
  - A chained request issued back-to-back uses the carry of the word captured in the same cycle, forwarded from add_cout when s1 is capturing. Otherwise it uses carry_q.
  - in_chain on the first request after reset uses carry_q=0.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined: when ovf=1, out_sum saturates. It becomes 0x7FFFFFFF if add_a[MSB]==0 and 0x80000000 if add_a[MSB]==1. out_ovf still reads 1, and out_zero is computed from the saturated value.
- Undefined: out_sum is the wrapped adder result.

Test Plan:
1. Single add: in_a=0x0000000F, in_b=0x00000001, in_cin=1, in_sub=0 -> add_b=0x00000001, add_cin=1; one cycle later out_valid=1, out_sum=0x00000011, out_cout=0, out_ovf=0, out_zero=0.
2. Subtract underflow: in_a=0, in_b=1, in_sub=1, in_cin=0 -> add_b=0xFFFFFFFE, add_cin=1; out_sum=0xFFFFFFFF, out_cout=0, out_ovf=0.
3. Overflow: in_a=0x80000000, in_b=0x80000000, add, in_cin=0 -> out_sum=0x00000000, out_cout=1, out_ovf=1, out_zero=1. With ADDSUB_SAT_EN: out_sum=0x80000000, out_zero=0.
4. 64-bit chain, back-to-back: word0 0xFFFFFFFF+0x00000001, cin=0 -> out_sum=0, out_cout=1. Word1 0+0 with in_chain=1 -> out_sum=0x00000001, out_cout=0.
5. Backpressure: out_ready=0, issue 4 requests on consecutive cycles (values 1..4) -> in_ready drops after the 3rd accept and the 4th is held. With out_ready=1, results come out in order 1,2,3,4 with no loss or duplication.
6. Reset mid-operation: rst_n=0 for one cycle while count=2 and s1_v=1 -> next cycle out_valid=0, in_ready=1, and a chained add uses carry 0.
